// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Brief    : Instruction fetch stage with in-order memory handshake, DEPTH-entry
//            prefetch FIFO and stale-response dropping after redirects.
//            Optional IF_PREFETCH_PERF_EN adds saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stop,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc_out,
    output logic            inst_valid,
    output logic [31:0]     perf_empty_cycles,
    output logic [31:0]     perf_dropped
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] C_NOP_INST = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;

    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] tag_mem_q  [DEPTH];

    logic [PW:0]     fifo_count;
    logic [CW:0]     inflight;
    logic            fifo_empty, fifo_full;
    logic            grant, push, pop, discard;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^jump_addr[1:0];

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // Buffered plus in-flight entries may never exceed the FIFO capacity.
    assign inflight   = {1'b0, fifo_count} + {1'b0, outstanding_q};

    assign imem_req   = !rst && !jump && (inflight < (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc_q;
    assign grant      = imem_req && imem_gnt;
    assign discard    = imem_rvalid && (jump || (drop_q != '0));
    assign push       = imem_rvalid && !jump && (drop_q == '0);
    assign pop        = !fifo_empty && !stop && !jump;

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_empty ? C_NOP_INST : data_mem_q[rd_ptr_q[PW-1:0]];
    assign pc_out     = fifo_empty ? '0 : pc_mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_wr_ptr_d  = tag_wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;
        if (jump) begin
            // Everything still in flight becomes stale; the new stream starts clean.
            fetch_pc_d    = {jump_addr[XLEN-1:2], 2'b00};
            outstanding_d = outstanding_q - CW'(imem_rvalid);
            drop_d        = outstanding_q - CW'(imem_rvalid);
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            tag_wr_ptr_d  = '0;
            tag_rd_ptr_d  = '0;
        end else begin
            outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
            if (grant) begin
                fetch_pc_d   = fetch_pc_q + XLEN'(4);
                tag_wr_ptr_d = tag_wr_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d     = wr_ptr_q + 1'b1;
                tag_rd_ptr_d = tag_rd_ptr_q + 1'b1;
            end
            if (discard) begin
                drop_d = drop_q - 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem_q[tag_wr_ptr_q[PW-1:0]] <= fetch_pc_q;
        end
        if (push) begin
            data_mem_q[wr_ptr_q[PW-1:0]] <= imem_rdata;
            pc_mem_q[wr_ptr_q[PW-1:0]]   <= tag_mem_q[tag_rd_ptr_q[PW-1:0]];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (outstanding_q == '0)));

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_empty_q, perf_empty_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;

    always_comb begin
        perf_empty_d   = perf_empty_q;
        perf_dropped_d = perf_dropped_q;
        if (fifo_empty && !stop && !jump && (perf_empty_q != '1)) begin
            perf_empty_d = perf_empty_q + 32'd1;
        end
        if (discard && (perf_dropped_q != '1)) begin
            perf_dropped_d = perf_dropped_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_empty_q   <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_empty_q   <= perf_empty_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_empty_cycles = perf_empty_q;
    assign perf_dropped      = perf_dropped_q;
`else
    assign perf_empty_cycles = 32'h0;
    assign perf_dropped      = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_queue
// Brief    : Directed and random stimulus for if_prefetch_queue against a
//            queue-based reference model and an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stop, jump, imem_gnt, imem_rvalid;
    logic [XLEN-1:0] jump_addr, imem_rdata;
    logic            imem_req, inst_valid;
    logic [XLEN-1:0] imem_addr, inst, pc_out;
    logic [31:0]     perf_empty_cycles, perf_dropped;

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stop              (stop),
        .jump              (jump),
        .jump_addr         (jump_addr),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .inst              (inst),
        .pc_out            (pc_out),
        .inst_valid        (inst_valid),
        .perf_empty_cycles (perf_empty_cycles),
        .perf_dropped      (perf_dropped)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;

    // Reference model: what the fetch stage should hold, in program order.
    logic [31:0] m_pc;
    int          m_out, m_stale;
    logic [31:0] m_fifo_pc[$], m_fifo_inst[$], m_tags[$];
    logic [31:0] m_empty, m_dropped;

    // In-order memory: granted addresses with the cycle they become due.
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    int          mem_last_due;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic mem_presenting(input logic [31:0] a);
        return (mem_addr.size() > 0) && (mem_due[0] <= cyc) && (mem_addr[0] == a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_stale = 0;
        m_fifo_pc.delete(); m_fifo_inst.delete(); m_tags.delete();
        m_empty = 0; m_dropped = 0;
        mem_addr.delete(); mem_due.delete(); mem_last_due = 0;
    endtask

    task automatic check_perf();
`ifdef IF_PREFETCH_PERF_EN
        chk("perf_empty_cycles", perf_empty_cycles, m_empty);
        chk("perf_dropped", perf_dropped, m_dropped);
`else
        chk("perf_empty_cycles", perf_empty_cycles, 32'h0);
        chk("perf_dropped", perf_dropped, 32'h0);
`endif
    endtask

    task automatic check_outputs(input logic jp);
        logic exp_req;
        exp_req = !jp && ((m_fifo_pc.size() + m_out) < DEPTH);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_fifo_pc.size() > 0));
        chk("pc_out", pc_out, (m_fifo_pc.size() > 0) ? m_fifo_pc[0] : 32'h0);
        chk("inst", inst, (m_fifo_pc.size() > 0) ? m_fifo_inst[0] : 32'h13);
        check_perf();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stop = 1'b0; jump = 1'b0; jump_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        model_reset();
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, 32'h13);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        check_perf();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc++;
    endtask

    task automatic step(input logic st, input logic jp, input logic [31:0] ja, input logic g);
        logic        rv, gr, mgr, pre_empty;
        logic [31:0] rd;
        int          due;
        @(negedge clk);
        rv = (mem_addr.size() > 0) && (mem_due[0] <= cyc);
        rd = rv ? mem_word(mem_addr[0]) : $urandom;
        stop = st; jump = jp; jump_addr = ja; imem_gnt = g;
        imem_rvalid = rv; imem_rdata = rd;
        #1;
        check_outputs(jp);
        gr = imem_req && g;
        pre_empty = (m_fifo_pc.size() == 0);
        if (jp) begin
            if (rv) begin
                m_out--;
                m_dropped++;
            end
            m_stale = m_out;
            m_fifo_pc.delete(); m_fifo_inst.delete(); m_tags.delete();
            m_pc = ja & ~32'h3;
        end else begin
            mgr = ((m_fifo_pc.size() + m_out) < DEPTH) && g;
            if (!pre_empty && !st) begin
                void'(m_fifo_pc.pop_front());
                void'(m_fifo_inst.pop_front());
            end
            if (rv) begin
                m_out--;
                if (m_stale > 0) begin
                    m_stale--;
                    m_dropped++;
                end else begin
                    m_fifo_pc.push_back(m_tags.pop_front());
                    m_fifo_inst.push_back(rd);
                end
            end
            if (mgr) begin
                m_tags.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                m_out++;
            end
            if (pre_empty && !st) m_empty++;
        end
        if (rv) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end
        if (gr) begin
            due = (cyc + lat > mem_last_due + 1) ? cyc + lat : mem_last_due + 1;
            mem_addr.push_back(imem_addr);
            mem_due.push_back(due);
            mem_last_due = due;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        logic done;
        rst = 1'b1; stop = 1'b0; jump = 1'b0; jump_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        model_reset();

        // Single-cycle memory: streaming fetch, one instruction per cycle.
        do_reset();
        lat = 1;
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Stall with a full FIFO, then a single pop frees one credit.
        do_reset();
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        chk("stall_imem_req", 32'(imem_req), 32'h0);
        chk("stall_inst_valid", 32'(inst_valid), 32'h1);
        chk("stall_pc_out", pc_out, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("credit_imem_req", 32'(imem_req), 32'h1);
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Three requests in flight when a redirect arrives.
        do_reset();
        lat = 4;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0101, 1'b1);
        #1;
        chk("redirect_addr", imem_addr, 32'h0000_0100);
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef IF_PREFETCH_PERF_EN
        chk("redirect_dropped", perf_dropped, 32'd3);
`endif

        // Redirect in the same cycle as the response for 0x4.
        do_reset();
        lat = 2;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (mem_presenting(32'h4)) begin
                step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
                done = 1'b1;
            end else begin
                step(1'b0, 1'b0, 32'h0, 1'b1);
            end
        end
        chk("jump_with_rvalid_seen", 32'(done), 32'h1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-stream with entries buffered and requests outstanding.
        lat = 3;
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
        do_reset();
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Fetch address wraps past the top of the address space.
        lat = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic: stalls, grant gaps, variable latency, redirects.
        for (int i = 0; i < 800; i++) begin
            lat = int'($urandom_range(1, 5));
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                     $urandom, ($urandom_range(0, 3) != 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
